cpu_sram_arbiter: RTL and testbench
===================================

# cpu_sram_arbiter

Arbiter that shares one synchronous single-port SRAM between the CPU's instruction-fetch requester and its data-access requester. It sits between the pipeline stages and the memory, taking the place of separate instruction and data SRAM ports. Requests use a pipelined req/addr_ok/data_ok handshake. Data requests have priority over instruction fetches. A starvation counter bounds how long fetch can be blocked, and responses are returned in order after a fixed RAM latency.

## Interface
Parameters:
- LAT, 1: RAM read latency in cycles, from ram_en to ram_rdata valid; legal range 1..4.
- STARVE_MAX, 3: maximum consecutive data grants while inst_req is pending; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- inst_req  in  1  fetch request valid.
- inst_addr  in  32  fetch byte address.
- inst_addr_ok  out  1  fetch request accepted this cycle.
- inst_data_ok  out  1  fetch response valid (one-cycle pulse).
- inst_rdata  out  32  fetch read data.
- data_req  in  1  data request valid.
- data_wr  in  1  1 = write, 0 = read.
- data_wstrb  in  4  byte enables for writes.
- data_addr  in  32  data byte address.
- data_wdata  in  32  write data.
- data_addr_ok  out  1  data request accepted this cycle.
- data_data_ok  out  1  data response valid (one-cycle pulse).
- data_rdata  out  32  data read data.
- ram_en  out  1  RAM access this cycle.
- ram_wen  out  4  RAM byte write enables.
- ram_addr  out  32  RAM byte address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid LAT cycles after ram_en.

## Operation
Requester contract:
- A requester holds req, addr, wr, wstrb and wdata stable until addr_ok is seen.
- A handshake is `req & addr_ok` in the same cycle.

Grant (combinational, one grant per cycle, no grant while reset=1):
- Data wins when `data_req & (~inst_req | starve_cnt < STARVE_MAX)`.
- Otherwise inst wins when `inst_req`.
- addr_ok is asserted only to the winner.

starve_cnt (4-bit register):
- Increments on a data grant while inst_req=1, saturating at STARVE_MAX.
- Clears on an inst grant or whenever inst_req=0.
- Clears on reset.

RAM port, driven combinationally from the winner:
- ram_en = any grant.
- ram_addr and ram_wdata come from the winner.
- ram_wen = data_wstrb for a granted data write, else 4'b0.
- ram_addr and ram_wdata are don't-care when ram_en=0.

Response tracking:
- A LAT-deep shift register of {valid, owner, is_write} advances every cycle.
- The head entry is loaded with {grant, grant_is_data, grant_is_data & data_wr}.
- When the tail entry is valid, the owner's data_ok pulses.
- rdata equals ram_rdata for reads and 32'h0 for writes.
- The non-owner's rdata and data_ok are 0.

Ordering and throughput:
- Responses are strictly in acceptance order.
- Throughput is one access per cycle and there is no back-pressure on responses.
- A write followed by a read to the same address in the next cycle returns the new data; the RAM provides write-first ordering.

## Timing
- Reset values:
  - starve_cnt = 0 and all shift-register valid bits = 0.
  - During reset=1: addr_ok, data_ok, ram_en and ram_wen are all 0; inst_rdata and data_rdata are 0.
- Acceptance latency: 0 cycles. addr_ok is asserted in the cycle of req when granted.
- Response latency: data_ok arrives exactly LAT cycles after the handshake cycle.
- Simultaneous inst_req and data_req:
  - Data is granted.
  - Inst is granted no later than after STARVE_MAX consecutive data grants.
- Reset mid-operation:
  - In-flight entries are discarded.
  - No data_ok is asserted in the cycles following reset deassertion for requests accepted before reset.
  - The first grant can occur in the first cycle with reset=0.
- starve_cnt at STARVE_MAX with inst_req=1:
  - Inst is granted and data_addr_ok=0 that cycle.
  - starve_cnt is 0 in the next cycle.

## Test plan
1. Fetch stream, LAT=1: inst_req=1 with addresses 0x0, 0x4, 0x8 in consecutive cycles, RAM words 0x11, 0x22, 0x33 -> inst_addr_ok=1 in each cycle; inst_data_ok in cycles 1, 2, 3 with inst_rdata 0x11, 0x22, 0x33.
2. Collision: inst_req and a data_req read of 0x40 in the same cycle -> data_addr_ok=1 and inst_addr_ok=0; inst is granted the next cycle; data_data_ok precedes inst_data_ok by 1 cycle.
3. Starvation, STARVE_MAX=3: data_req and inst_req both held high for 8 cycles -> grant sequence D,D,D,I,D,D,D,I.
4. Byte write: data_wr=1, wstrb=4'b0011, addr=0x100, wdata=0xAABBCCDD over prior contents 0x12345678 -> ram_wen=4'b0011; data_data_ok after LAT with data_rdata=0; a following read of 0x100 returns 0x1234CCDD.
5. Pipelined mix, LAT=3: issue I, D, I, D-write back-to-back -> four data_ok pulses 3 cycles after each handshake, in order, each to the correct owner with the correct rdata.
6. Reset mid-flight, LAT=3: two requests accepted, then reset=1 for 1 cycle -> no data_ok in the following 4 cycles; a new fetch after reset completes normally.

Source files
------------

// File: rtl/cpu_sram_arbiter.sv
// cpu_sram_arbiter
//   Shares one synchronous single-port SRAM between the instruction-fetch
//   requester and the data-access requester of the CPU. Data requests win
//   over fetches, but a starvation counter forces a fetch grant after
//   STARVE_MAX consecutive data grants while a fetch is waiting. Responses
//   come back in acceptance order exactly LAT cycles after the handshake.
//
// Parameters
//   LAT         RAM read latency in cycles (1..4)
//   STARVE_MAX  consecutive data grants allowed while inst_req is pending (1..15)
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   inst_req/inst_addr              fetch request
//   inst_addr_ok                    fetch accepted this cycle
//   inst_data_ok/inst_rdata         fetch response
//   data_req/data_wr/data_wstrb/
//   data_addr/data_wdata            data request
//   data_addr_ok                    data accepted this cycle
//   data_data_ok/data_rdata         data response (rdata is 0 for writes)
//   ram_en/ram_wen/ram_addr/
//   ram_wdata/ram_rdata             single-port SRAM interface
module cpu_sram_arbiter #(
    parameter int LAT        = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        ram_en,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    logic       data_win;
    logic       inst_win;
    logic       grant;

    // Response tracking pipe: index 0 is loaded at the grant edge, index
    // LAT-1 lines up with ram_rdata for that access.
    logic       vld_p [LAT];
    logic       own_p [LAT];   // 1 = data requester owns the entry
    logic       wr_p  [LAT];   // 1 = entry is a write (returns zero data)

    logic       tail_vld;

    // Saturating increment of the starvation counter.
    function automatic logic [3:0] starve_inc(input logic [3:0] cnt);
        return (cnt < STARVE_LIM) ? cnt + 4'd1 : cnt;
    endfunction

    // ---- stage 0: combinational grant and RAM drive ----
    always_comb begin
        data_win = ~reset & data_req & (~inst_req | (starve_cnt < STARVE_LIM));
        inst_win = ~reset & inst_req & ~data_win;
    end

    assign grant        = data_win | inst_win;
    assign inst_addr_ok = inst_win;
    assign data_addr_ok = data_win;

    assign ram_en    = grant;
    assign ram_wen   = (data_win & data_wr) ? data_wstrb : 4'b0000;
    assign ram_addr  = data_win ? data_addr : inst_addr;
    assign ram_wdata = data_wdata;   // only meaningful on a data write

    // The counter only measures an uninterrupted wait: a fetch grant or a
    // cycle without a fetch request restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (!inst_req || inst_win) begin
            starve_cnt <= 4'd0;
        end else if (data_win) begin
            starve_cnt <= starve_inc(starve_cnt);
        end
    end

    // ---- stages 1..LAT: response tracking ----
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < LAT; k++) begin
                vld_p[k] <= 1'b0;
            end
        end else begin
            vld_p[0] <= grant;
            for (int k = 1; k < LAT; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        own_p[0] <= data_win;
        wr_p[0]  <= data_win & data_wr;
        for (int k = 1; k < LAT; k++) begin
            own_p[k] <= own_p[k-1];
            wr_p[k]  <= wr_p[k-1];
        end
    end

    // ---- response output ----
    // Gating with reset keeps entries that are about to be flushed from
    // signalling while reset is held.
    assign tail_vld     = vld_p[LAT-1] & ~reset;
    assign inst_data_ok = tail_vld & ~own_p[LAT-1];
    assign data_data_ok = tail_vld &  own_p[LAT-1];
    assign inst_rdata   = inst_data_ok ? ram_rdata : 32'h0;
    assign data_rdata   = (data_data_ok & ~wr_p[LAT-1]) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Testbench for cpu_sram_arbiter. Two instances (LAT=1 and LAT=3) share the
// same requester stimulus, each with its own SRAM model. A reference model
// decides every cycle who should win, which RAM signals should appear and
// which response is due in which future cycle.
module tb_cpu_sram_arbiter;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int SMAX  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;

    logic        ia_ok  [2];
    logic        id_ok  [2];
    logic [31:0] i_rd   [2];
    logic        da_ok  [2];
    logic        dd_ok  [2];
    logic [31:0] d_rd   [2];
    logic        r_en   [2];
    logic [3:0]  r_wen  [2];
    logic [31:0] r_addr [2];
    logic [31:0] r_wdata[2];
    logic [31:0] r_rdata[2];

    cpu_sram_arbiter #(.LAT(LAT_A), .STARVE_MAX(SMAX)) dut_a (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(ia_ok[0]), .inst_data_ok(id_ok[0]), .inst_rdata(i_rd[0]),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(da_ok[0]), .data_data_ok(dd_ok[0]), .data_rdata(d_rd[0]),
        .ram_en(r_en[0]), .ram_wen(r_wen[0]), .ram_addr(r_addr[0]),
        .ram_wdata(r_wdata[0]), .ram_rdata(r_rdata[0])
    );

    cpu_sram_arbiter #(.LAT(LAT_B), .STARVE_MAX(SMAX)) dut_b (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(ia_ok[1]), .inst_data_ok(id_ok[1]), .inst_rdata(i_rd[1]),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(da_ok[1]), .data_data_ok(dd_ok[1]), .data_rdata(d_rd[1]),
        .ram_en(r_en[1]), .ram_wen(r_wen[1]), .ram_addr(r_addr[1]),
        .ram_wdata(r_wdata[1]), .ram_rdata(r_rdata[1])
    );

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    function automatic int lat_of(input int g);
        return (g == 0) ? LAT_A : LAT_B;
    endfunction

    // SRAM models: write-first, read data appears L cycles after ram_en.
    for (genvar g = 0; g < 2; g++) begin : g_ram
        localparam int L = (g == 0) ? LAT_A : LAT_B;
        logic [31:0] mem  [256];
        logic [31:0] pipe [L];
        logic [31:0] w;
        bit          inited = 1'b0;
        always @(posedge clk) begin
            if (!inited) begin
                for (int i = 0; i < 256; i++) mem[i] = init_word(i);
                inited = 1'b1;
            end
            if (r_en[g]) begin
                w = mem[r_addr[g][9:2]];
                for (int b = 0; b < 4; b++)
                    if (r_wen[g][b]) w[8*b +: 8] = r_wdata[g][8*b +: 8];
                mem[r_addr[g][9:2]] = w;
                pipe[0] <= w;
            end else begin
                pipe[0] <= 32'hDEADBEEF;
            end
            for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
        end
        assign r_rdata[g] = pipe[L-1];
    end

    // Reference model state
    logic [31:0] ref_mem [256];
    int          scnt;                 // consecutive data wins while a fetch waits
    bit          ev [2][16];           // response due in cycle slot
    bit          eo [2][16];           // 1 = due to data requester
    logic [31:0] ed [2][16];           // expected rdata
    int          cyc;
    int          vec;
    int          err;
    logic        seen_ia [2];
    logic [31:0] last_drd [2];
    logic [7:0]  gseq_a, gseq_b;
    bit          ig, dg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic drv(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                       input logic [3:0] ds, input logic [31:0] da, input logic [31:0] dd);
        inst_req   = ir;
        inst_addr  = ia;
        data_req   = dr;
        data_wr    = dw;
        data_wstrb = ds;
        data_addr  = da;
        data_wdata = dd;
    endtask

    // One cycle: called just after a falling edge with inputs driven.
    task automatic step(output bit igr, output bit dgr);
        int          s;
        int          idx;
        int          slot;
        bit          e_i, e_d;
        logic [31:0] w;
        #1;
        dgr = !reset && data_req && (!inst_req || scnt < SMAX);
        igr = !reset && inst_req && !dgr;
        if (reset)
            for (int g = 0; g < 2; g++)
                for (int j = 0; j < 16; j++) ev[g][j] = 1'b0;
        s = cyc % 16;
        for (int g = 0; g < 2; g++) begin
            seen_ia[g] = ia_ok[g];
            if (dd_ok[g]) last_drd[g] = d_rd[g];
            e_i = ev[g][s] && !eo[g][s];
            e_d = ev[g][s] &&  eo[g][s];
            chk("inst_addr_ok", 32'(ia_ok[g]), 32'(igr));
            chk("data_addr_ok", 32'(da_ok[g]), 32'(dgr));
            chk("ram_en", 32'(r_en[g]), 32'(igr | dgr));
            chk("ram_wen", 32'(r_wen[g]), (dgr && data_wr) ? 32'(data_wstrb) : 32'h0);
            if (igr || dgr) chk("ram_addr", r_addr[g], dgr ? data_addr : inst_addr);
            if (dgr && data_wr) chk("ram_wdata", r_wdata[g], data_wdata);
            chk("inst_data_ok", 32'(id_ok[g]), 32'(e_i));
            chk("inst_rdata", i_rd[g], e_i ? ed[g][s] : 32'h0);
            chk("data_data_ok", 32'(dd_ok[g]), 32'(e_d));
            chk("data_rdata", d_rd[g], e_d ? ed[g][s] : 32'h0);
            ev[g][s] = 1'b0;
        end
        if (igr || dgr) begin
            idx = dgr ? int'(data_addr[9:2]) : int'(inst_addr[9:2]);
            if (dgr && data_wr) begin
                for (int b = 0; b < 4; b++)
                    if (data_wstrb[b]) ref_mem[idx][8*b +: 8] = data_wdata[8*b +: 8];
                w = 32'h0;
            end else begin
                w = ref_mem[idx];
            end
            for (int g = 0; g < 2; g++) begin
                slot = (cyc + lat_of(g)) % 16;
                ev[g][slot] = 1'b1;
                eo[g][slot] = dgr;
                ed[g][slot] = w;
            end
        end
        if (reset || !inst_req || igr) scnt = 0;
        else if (dgr && scnt < SMAX) scnt++;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drv(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            step(ig, dg);
        end
    endtask

    initial begin
        vec = 0; err = 0; cyc = 0; scnt = 0;
        last_drd[0] = 32'h0; last_drd[1] = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        for (int g = 0; g < 2; g++)
            for (int j = 0; j < 16; j++) begin
                ev[g][j] = 1'b0; eo[g][j] = 1'b0; ed[g][j] = 32'h0;
            end
        reset = 1'b1;
        drv(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);

        // Reset: requests present but nothing may be granted
        drv(1'b1, 32'h0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
        step(ig, dg);
        step(ig, dg);
        reset = 1'b0;
        idle(1);

        // Fetch stream over words 0x11, 0x22, 0x33
        for (int k = 0; k < 3; k++) begin
            drv(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'(k * 4), 32'(32'h11 * (k + 1)));
            step(ig, dg);
        end
        for (int k = 0; k < 3; k++) begin
            drv(1'b1, 32'(k * 4), 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            step(ig, dg);
        end
        idle(4);

        // Collision then sustained contention: D,D,D,I,D,D,D,I
        for (int k = 0; k < 8; k++) begin
            drv(1'b1, 32'h8, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
            step(ig, dg);
            gseq_a[k] = seen_ia[0];
            gseq_b[k] = seen_ia[1];
        end
        chk("starve_seq_lat1", 32'(gseq_a), 32'h88);
        chk("starve_seq_lat3", 32'(gseq_b), 32'h88);
        idle(4);

        // Byte write merge then read-back
        drv(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h100, 32'h12345678);
        step(ig, dg);
        drv(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hAABBCCDD);
        step(ig, dg);
        drv(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        step(ig, dg);
        idle(4);
        chk("bytewr_readback_lat1", last_drd[0], 32'h1234CCDD);
        chk("bytewr_readback_lat3", last_drd[1], 32'h1234CCDD);

        // Pipelined mix: I, D read, I, D write back-to-back
        drv(1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);          step(ig, dg);
        drv(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);         step(ig, dg);
        drv(1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);          step(ig, dg);
        drv(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h44, 32'hCAFEF00D); step(ig, dg);
        idle(4);

        // Reset with two accesses in flight
        drv(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);          step(ig, dg);
        drv(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);        step(ig, dg);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(4);
        drv(1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);          step(ig, dg);
        idle(4);

        // Randomized traffic, requests held until accepted
        drv(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        ig = 1'b0; dg = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!inst_req || ig) begin
                inst_req  = ($urandom_range(0, 3) != 0);
                inst_addr = 32'($urandom_range(0, 31)) << 2;
            end
            if (!data_req || dg) begin
                data_req   = ($urandom_range(0, 3) != 0);
                data_wr    = $urandom_range(0, 1) == 1;
                data_wstrb = 4'($urandom);
                data_addr  = 32'($urandom_range(0, 31)) << 2;
                data_wdata = $urandom;
            end
            reset = ($urandom_range(0, 49) == 0);
            step(ig, dg);
        end
        reset = 1'b0;
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
